// File: rtl/inert_spi_sched.sv
// SPI transaction scheduler for the iNEMO inertial sensor.
// After power-up hold-off it writes the sensor configuration, then shares the
// single SPI monarch between INT-triggered data bursts and a host port.
// Burst bytes are assembled into 16-bit raw readings published with vld.
// Optional build macro INERT_SCHED_ACCEL_EN: extends the burst to 10 reads
// and drives ax_raw/ay_raw; otherwise the burst is 6 reads and they stay 0.
module inert_spi_sched #(
  parameter bit FAST_SIM = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        INT,
  output logic        wrt,
  output logic [15:0] cmd,
  input  logic        done,
  input  logic [15:0] rd_data,
  input  logic        host_req,
  input  logic [15:0] host_cmd,
  output logic        host_done,
  output logic [15:0] host_rdata,
  output logic        init_done,
  output logic [15:0] ptch_raw,
  output logic [15:0] roll_raw,
  output logic [15:0] yaw_raw,
  output logic [15:0] ax_raw,
  output logic [15:0] ay_raw,
  output logic        vld
);

`ifdef INERT_SCHED_ACCEL_EN
  localparam int unsigned NumReads = 10;
`else
  localparam int unsigned NumReads = 6;
`endif
  localparam logic [3:0]  LastIdx = 4'(NumReads - 1);
  localparam logic [15:0] PwrupTc = FAST_SIM ? 16'h01FF : 16'hFFFF;

  typedef enum logic [2:0] {
    StPwrup, StInitWr, StInitWait, StIdle, StBrstWr, StBrstWait, StHostWr, StHostWait
  } state_e;

  state_e      state_q;
  logic [15:0] pwr_cnt_q;
  logic [1:0]  init_idx_q;
  logic [3:0]  brst_idx_q;
  logic [2:0]  int_sync_q;
  logic        int_pend_q;
  logic        last_grant_q;  // 1: host was granted last
  logic [15:0] sh_ptch_q, sh_roll_q;
  logic [7:0]  sh_last_lo_q;  // low byte of the final reading in the burst
`ifdef INERT_SCHED_ACCEL_EN
  logic [15:0] sh_yaw_q, sh_ax_q;
`endif

  logic        int_edge;
  logic        host_ok;
  logic        grant_brst;
  logic        grant_host;
  logic [15:0] init_cmd;

  // Two-flop synchronizer plus edge register for the sensor INT line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) int_sync_q <= 3'b000;
    else        int_sync_q <= {int_sync_q[1:0], INT};
  end

  // Edge detect, IDLE arbitration and config-write table.
  always_comb begin
    int_edge   = int_sync_q[1] & ~int_sync_q[2];
    // host_req is still high during its own host_done cycle; do not regrant it.
    host_ok    = host_req & ~host_done;
    grant_brst = int_pend_q & (~host_ok | last_grant_q);
    grant_host = host_ok & ~grant_brst;
    case (init_idx_q)
      2'd0:    init_cmd = 16'h0D02;
      2'd1:    init_cmd = 16'h1062;
      2'd2:    init_cmd = 16'h1162;
      default: init_cmd = 16'h1460;
    endcase
  end

  // Scheduler FSM with registered SPI, host and reading outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StPwrup;
      pwr_cnt_q    <= '0;
      init_idx_q   <= '0;
      brst_idx_q   <= '0;
      int_pend_q   <= 1'b0;
      last_grant_q <= 1'b1;
      wrt          <= 1'b0;
      cmd          <= '0;
      host_done    <= 1'b0;
      host_rdata   <= '0;
      init_done    <= 1'b0;
      vld          <= 1'b0;
      ptch_raw     <= '0;
      roll_raw     <= '0;
      yaw_raw      <= '0;
      sh_ptch_q    <= '0;
      sh_roll_q    <= '0;
      sh_last_lo_q <= '0;
`ifdef INERT_SCHED_ACCEL_EN
      ax_raw       <= '0;
      ay_raw       <= '0;
      sh_yaw_q     <= '0;
      sh_ax_q      <= '0;
`endif
    end else begin
      wrt       <= 1'b0;
      vld       <= 1'b0;
      host_done <= 1'b0;
      if (int_edge) int_pend_q <= 1'b1;
      case (state_q)
        StPwrup: begin
          pwr_cnt_q <= pwr_cnt_q + 16'd1;
          if (pwr_cnt_q == PwrupTc) state_q <= StInitWr;
        end
        StInitWr: begin
          wrt     <= 1'b1;
          cmd     <= init_cmd;
          state_q <= StInitWait;
        end
        StInitWait: begin
          if (done) begin
            if (init_idx_q == 2'd3) begin
              init_done <= 1'b1;
              state_q   <= StIdle;
            end else begin
              init_idx_q <= init_idx_q + 2'd1;
              state_q    <= StInitWr;
            end
          end
        end
        StIdle: begin
          if (grant_brst) begin
            // A fresh edge in the grant cycle must survive the clear.
            int_pend_q   <= int_edge;
            brst_idx_q   <= '0;
            last_grant_q <= 1'b0;
            state_q      <= StBrstWr;
          end else if (grant_host) begin
            cmd          <= host_cmd;
            last_grant_q <= 1'b1;
            state_q      <= StHostWr;
          end
        end
        StBrstWr: begin
          wrt     <= 1'b1;
          cmd     <= {8'hA2 + {4'h0, brst_idx_q}, 8'h00};
          state_q <= StBrstWait;
        end
        StBrstWait: begin
          if (done) begin
            if (brst_idx_q == LastIdx) begin
              // Publish every reading at once; the final byte comes straight from rd_data.
              vld      <= 1'b1;
              ptch_raw <= sh_ptch_q;
              roll_raw <= sh_roll_q;
`ifdef INERT_SCHED_ACCEL_EN
              yaw_raw  <= sh_yaw_q;
              ax_raw   <= sh_ax_q;
              ay_raw   <= {rd_data[7:0], sh_last_lo_q};
`else
              yaw_raw  <= {rd_data[7:0], sh_last_lo_q};
`endif
              state_q  <= StIdle;
            end else begin
              case (brst_idx_q)
                4'd0: sh_ptch_q[7:0]  <= rd_data[7:0];
                4'd1: sh_ptch_q[15:8] <= rd_data[7:0];
                4'd2: sh_roll_q[7:0]  <= rd_data[7:0];
                4'd3: sh_roll_q[15:8] <= rd_data[7:0];
`ifdef INERT_SCHED_ACCEL_EN
                4'd4: sh_yaw_q[7:0]   <= rd_data[7:0];
                4'd5: sh_yaw_q[15:8]  <= rd_data[7:0];
                4'd6: sh_ax_q[7:0]    <= rd_data[7:0];
                4'd7: sh_ax_q[15:8]   <= rd_data[7:0];
                4'd8: sh_last_lo_q    <= rd_data[7:0];
`else
                4'd4: sh_last_lo_q    <= rd_data[7:0];
`endif
                default: ;
              endcase
              brst_idx_q <= brst_idx_q + 4'd1;
              state_q    <= StBrstWr;
            end
          end
        end
        StHostWr: begin
          wrt     <= 1'b1;
          state_q <= StHostWait;
        end
        StHostWait: begin
          if (done) begin
            host_rdata <= rd_data;
            host_done  <= 1'b1;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StPwrup;
      endcase
    end
  end

`ifndef INERT_SCHED_ACCEL_EN
  assign ax_raw = '0;
  assign ay_raw = '0;
`endif

endmodule

// File: tb/tb_inert_spi_sched.sv
// Scoreboard bench for inert_spi_sched: stimulus pushes expected SPI commands,
// host responses and burst readings; a monitor pops and compares them when the
// DUT presents wrt, host_done or vld. A small SPI model answers each wrt.
module tb_inert_spi_sched;

`ifdef INERT_SCHED_ACCEL_EN
  localparam int NumReads = 10;
`else
  localparam int NumReads = 6;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, INT, wrt, done, host_req, host_done, init_done, vld;
  logic [15:0] cmd, rd_data, host_cmd, host_rdata;
  logic [15:0] ptch_raw, roll_raw, yaw_raw, ax_raw, ay_raw;

  inert_spi_sched #(.FAST_SIM(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .INT       (INT),
    .wrt       (wrt),
    .cmd       (cmd),
    .done      (done),
    .rd_data   (rd_data),
    .host_req  (host_req),
    .host_cmd  (host_cmd),
    .host_done (host_done),
    .host_rdata(host_rdata),
    .init_done (init_done),
    .ptch_raw  (ptch_raw),
    .roll_raw  (roll_raw),
    .yaw_raw   (yaw_raw),
    .ax_raw    (ax_raw),
    .ay_raw    (ay_raw),
    .vld       (vld)
  );

  typedef struct packed {
    logic [15:0] p, r, y, ax, ay;
  } raw_t;

  logic [15:0] exp_cmd[$];
  logic [15:0] exp_host[$];
  raw_t        exp_raw[$];
  raw_t        last_raw;

  int checks = 0;
  int errors = 0;
  int cyc, brst_wrt_cnt, done_cnt, prev_vld_cyc, last_gap, served, bursts_issued, nb;
  bit wrt_seen, first_wrt_chk, vld_prev, hd_prev;

  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Reading r of burst n: base value plus n*0x0111.
  function automatic logic [15:0] val(int r, int n);
    logic [15:0] base;
    case (r)
      0:       base = 16'h1234;
      1:       base = 16'h5678;
      2:       base = 16'h9ABC;
      3:       base = 16'hDEF0;
      default: base = 16'h0F1E;
    endcase
    return base + 16'(n) * 16'h0111;
  endfunction

  function automatic raw_t exp_burst(int n);
    raw_t e;
    e.p = val(0, n);
    e.r = val(1, n);
    e.y = val(2, n);
`ifdef INERT_SCHED_ACCEL_EN
    e.ax = val(3, n);
    e.ay = val(4, n);
`else
    e.ax = 16'h0000;
    e.ay = 16'h0000;
`endif
    return e;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic push_init();
    exp_cmd.push_back(16'h0D02);
    exp_cmd.push_back(16'h1062);
    exp_cmd.push_back(16'h1162);
    exp_cmd.push_back(16'h1460);
  endtask

  task automatic push_burst();
    logic [7:0] a;
    for (int i = 0; i < NumReads; i++) begin
      a = 8'(8'hA2 + i);
      exp_cmd.push_back({a, 8'h00});
    end
    exp_raw.push_back(exp_burst(bursts_issued));
    bursts_issued++;
  endtask

  task automatic pulse_int();
    @(negedge clk);
    INT = 1'b1;
    repeat (4) @(negedge clk);
    INT = 1'b0;
  endtask

  // Raise INT, then host_req once int_pend is set, so both are pending together.
  task automatic tie(logic [15:0] hc);
    @(negedge clk);
    INT = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    host_req = 1'b1;
    host_cmd = hc;
    repeat (2) @(negedge clk);
    INT = 1'b0;
  endtask

  task automatic flush();
    exp_cmd.delete();
    exp_host.delete();
    exp_raw.delete();
  endtask

  task automatic wait_drain(string nm);
    int k = 0;
    while ((exp_cmd.size() != 0 || exp_raw.size() != 0 || exp_host.size() != 0) && k < 3000) begin
      @(negedge clk);
      if (host_done) host_req = 1'b0;
      k++;
    end
    checks++;
    if (k >= 3000) begin
      errors++;
      $display("FAIL %s_timeout actual=%0d/%0d/%0d left required=0", nm, exp_cmd.size(),
               exp_raw.size(), exp_host.size());
      flush();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_wrts(int n, string nm);
    int k = 0;
    while (brst_wrt_cnt < n && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk(nm, 32'(brst_wrt_cnt >= n), 1);
  endtask

  // SPI monarch model: done two cycles after wrt, byte data for burst reads.
  initial begin
    logic [15:0] c, v;
    int i;
    done = 1'b0;
    rd_data = '0;
    forever begin
      @(negedge clk);
      if (wrt && rst_n) begin
        c = cmd;
        repeat (2) @(negedge clk);
        if (c[15:8] >= 8'hA2 && c[15:8] <= 8'hAB) begin
          i = int'(c[15:8] - 8'hA2);
          if (i == 0) begin
            nb = served;
            served++;
          end
          v = val(i / 2, nb);
          rd_data = {8'hEE, (i % 2 == 1) ? v[15:8] : v[7:0]};
        end else if (c == 16'h8F00) begin
          rd_data = 16'h006A;
        end else begin
          rd_data = {8'hC3, c[15:8]};
        end
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
      end
    end
  end

  // Monitor: pop and compare on every DUT-presented event.
  initial begin
    raw_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (wrt) begin
          if (first_wrt_chk) begin
            checks++;
            if (cyc < 512 || cyc > 514) begin
              errors++;
              $display("FAIL first_wrt_cycle actual=%0d required=513", cyc);
            end
            first_wrt_chk = 1'b0;
          end
          wrt_seen = 1'b1;
          if (exp_cmd.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_wrt actual=%0h required=none", cmd);
          end else begin
            chk("cmd", cmd, exp_cmd.pop_front());
          end
          if (cmd[15:8] >= 8'hA2 && cmd[15:8] <= 8'hAB) begin
            if (cmd[15:8] == 8'hA2) last_gap = cyc - prev_vld_cyc;
            brst_wrt_cnt++;
            chk("ptch_hold", ptch_raw, last_raw.p);
            chk("roll_hold", roll_raw, last_raw.r);
            chk("yaw_hold", yaw_raw, last_raw.y);
            chk("ay_hold", ay_raw, last_raw.ay);
          end
        end
        if (done && wrt_seen) done_cnt++;
        if (vld) begin
          chk("vld_single", vld_prev, 0);
          chk("brst_wrt_cnt", brst_wrt_cnt, NumReads);
          brst_wrt_cnt = 0;
          prev_vld_cyc = cyc;
          if (exp_raw.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_vld actual=1 required=0");
          end else begin
            e = exp_raw.pop_front();
            chk("ptch_raw", ptch_raw, e.p);
            chk("roll_raw", roll_raw, e.r);
            chk("yaw_raw", yaw_raw, e.y);
            chk("ax_raw", ax_raw, e.ax);
            chk("ay_raw", ay_raw, e.ay);
            last_raw = e;
          end
        end
        if (host_done) begin
          chk("host_done_single", hd_prev, 0);
          if (exp_host.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_host_done actual=1 required=0");
          end else begin
            chk("host_rdata", host_rdata, exp_host.pop_front());
          end
        end
      end
      vld_prev = vld;
      hd_prev  = host_done;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int k;
    rst_n = 1'b0;
    INT = 1'b0;
    host_req = 1'b0;
    host_cmd = '0;
    first_wrt_chk = 1'b1;
    wrt_seen = 1'b0;
    last_raw = '0;
    repeat (3) @(negedge clk);
    chk("rst_wrt", wrt, 0);
    chk("rst_cmd", cmd, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_vld", vld, 0);
    chk("rst_host_done", host_done, 0);
    chk("rst_host_rdata", host_rdata, 0);
    chk("rst_ptch", ptch_raw, 0);

    // Power-up hold-off and configuration writes.
    push_init();
    rst_n = 1'b1;
    k = 0;
    while (!init_done && k < 1500) begin
      @(negedge clk);
      k++;
    end
    chk("init_done", init_done, 1);
    chk("init_done_cnt", done_cnt, 4);
    chk("init_cmds_left", exp_cmd.size(), 0);

    // Lone host read.
    exp_cmd.push_back(16'h8F00);
    exp_host.push_back(16'h006A);
    host_cmd = 16'h8F00;
    host_req = 1'b1;
    wait_drain("host0");

    // Tie after reset: burst first, then host.
    push_burst();
    exp_cmd.push_back(16'h8E00);
    exp_host.push_back(16'hC38E);
    tie(16'h8E00);
    wait_drain("tie0");

    // Lone burst leaves last grant on burst.
    push_burst();
    pulse_int();
    wait_drain("burst1");

    // Tie again: host now wins, burst follows.
    exp_cmd.push_back(16'h8F00);
    exp_host.push_back(16'h006A);
    push_burst();
    tie(16'h8F00);
    wait_drain("tie1");

    // INT during a burst yields a second burst right after re-arbitration.
    push_burst();
    push_burst();
    pulse_int();
    wait_wrts(3, "mid_burst_reach");
    pulse_int();
    wait_drain("int_during_burst");
    chk("rearb_gap", last_gap, 2);

    // Reset mid-burst clears everything and re-runs init; INT during power-up is kept.
    push_burst();
    pulse_int();
    wait_wrts(3, "reset_burst_reach");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_wrt", wrt, 0);
    chk("midrst_cmd", cmd, 0);
    chk("midrst_init_done", init_done, 0);
    chk("midrst_host_rdata", host_rdata, 0);
    chk("midrst_ptch", ptch_raw, 0);
    chk("midrst_yaw", yaw_raw, 0);
    flush();
    brst_wrt_cnt = 0;
    done_cnt = 0;
    wrt_seen = 1'b0;
    last_raw = '0;
    first_wrt_chk = 1'b1;
    repeat (3) @(negedge clk);
    push_init();
    push_burst();
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    pulse_int();
    wait_drain("reinit_burst");
    chk("reinit_done", init_done, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inert_spi_sched.md
# inert_spi_sched

SPI transaction scheduler between the inertial interface's integration datapath and the single SPI monarch that talks to the iNEMO sensor. After a power-up hold-off it writes the sensor configuration. It then shares the SPI monarch between INT-triggered data bursts and a host register-access port. Burst bytes are assembled into raw 16-bit readings with a one-cycle valid strobe.

## Interface
- FAST_SIM, 0, 1 shortens power-up hold-off from 2^16 to 2^9 clocks
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- INT  in  1  sensor data-ready (asynchronous, double-flopped internally)
- wrt  out  1  one-cycle start pulse to SPI monarch
- cmd  out  16  SPI command word, stable from wrt until done
- done  in  1  one-cycle SPI transaction complete
- rd_data  in  16  SPI response; low byte is register data
- host_req  in  1  host access request, held high until host_done
- host_cmd  in  16  host command, sampled on grant cycle
- host_done  out  1  one-cycle host transaction complete
- host_rdata  out  16  response of last host transaction
- init_done  out  1  configuration writes complete (sticky)
- ptch_raw, roll_raw, yaw_raw, ax_raw, ay_raw  out  16 each  assembled readings
- vld  out  1  one-cycle pulse, all raw readings updated

## Operation
- States: PWRUP, INIT_WR, INIT_WAIT, IDLE, BRST_WR, BRST_WAIT, HOST_WR, HOST_WAIT.
- PWRUP: 16-bit (FAST_SIM: 9-bit) counter runs; on terminal count -> INIT_WR.
- Init writes in order: 0x0D02, 0x1062, 0x1162, 0x1460; 2-bit index; after 4th done -> IDLE, init_done=1.
- INT edge detector on synchronized INT sets int_pend; cleared on entry to BRST_WR at index 0.
- Burst read commands: {8'hA2..8'hAB, 8'h00}: ptch L/H, roll L/H, yaw L/H, AX L/H, AY L/H. Byte i captured from rd_data[7:0] on its done.
- vld pulses the cycle after the final burst byte's done; all raw outputs update together then (double-buffered; partial bursts never visible).
- IDLE arbitration: one-bit last_grant. If only one of int_pend/host_req pending, it wins. If both pending, the one not last granted wins.
- No preemption: a burst runs to completion even if host_req rises; a host transaction completes even if INT fires (int_pend remembered).
- Host: grant latches host_cmd into cmd; on done, host_rdata<=rd_data, host_done pulses, -> IDLE. host_req must drop the cycle after host_done; if still high it is a new request.
- host_req and INT are ignored (int_pend still latches) before init_done.
- INT edge during a burst sets int_pend again -> another burst after arbitration.

## Timing
- Reset: state PWRUP, wrt=0, cmd=0, host_done=0, host_rdata=0, init_done=0, vld=0, all raw=0, int_pend=0, last_grant=host (so first tie goes to burst).
- Reset mid-transaction aborts immediately; no restart handshake with the SPI monarch beyond its own reset.
- wrt asserts the cycle after entry to any *_WR state; cmd registered same edge.
- Next wrt issues exactly one cycle after the previous done (WAIT -> WR -> wrt).
- INT to int_pend: 3 clocks (2 sync + edge register).
- Host grant latency from IDLE: 1 clock to wrt.

## Configuration
- INERT_SCHED_ACCEL_EN defined: burst is 10 reads (through 0xAB), ax_raw/ay_raw driven.
- Undefined: burst is 6 reads (0xA2-0xA7), ax_raw/ay_raw held 0, vld follows 6th byte.

## Test plan
- Reset release, FAST_SIM=1 -> first wrt at clock 513±1, cmds 0x0D02,0x1062,0x1162,0x1460 in order; init_done after 4th done.
- SPI model returns 0x34,0x12 for ptch L/H, etc.; INT rising -> ptch_raw=0x1234, vld single pulse after last done, raw outputs unchanged mid-burst.
- host_req with host_cmd=0x8F00, model returns 0x006A -> host_rdata=0x006A, host_done single pulse, wrt exactly once.
- INT edge and host_req same cycle in IDLE after reset -> burst first, host second; repeat -> host first (alternation).
- INT edge during burst -> second burst begins one cycle after first vld path completes arbitration; no lost event.
- rst_n low mid-burst -> all outputs 0 immediately, state PWRUP, init sequence re-runs; with/without INERT_SCHED_ACCEL_EN burst wrt count 10/6.
